// File: rtl/nexys4ddr_uart_pkg.sv
// ---------------------------------------------------------------------------
// nexys4ddr_uart_pkg
// Shared types and helpers for the Nexys 4 DDR on-board UART.
//   uart_state_e : state encoding shared by the RX and TX framers
//   calc_div     : clocks per bit, rounded to nearest
// ---------------------------------------------------------------------------
package nexys4ddr_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Clocks per bit, rounded to the nearest integer.
  function automatic int unsigned calc_div(input int unsigned freq, input int unsigned baud);
    return (freq + (baud / 32'd2)) / baud;
  endfunction

endpackage

// File: rtl/nexys4ddr_uart_if.sv
// ---------------------------------------------------------------------------
// nexys4ddr_uart_if
// Byte-stream bus between the SoC side (master) and the UART (slave).
//   tx_data/tx_valid/tx_ready : bytes to transmit, valid/ready handshake
//   rx_data/rx_valid/rx_ready : received bytes, head of the RX FIFO
//   rx_overflow               : sticky, a received byte was dropped
//   rx_frame_err              : one-cycle pulse on a bad stop bit
// ---------------------------------------------------------------------------
interface nexys4ddr_uart_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_overflow;
  logic       rx_frame_err;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, rx_overflow, rx_frame_err
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, rx_overflow, rx_frame_err
  );
endinterface

// File: rtl/nexys4ddr_uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock show-ahead FIFO with a registered occupancy count.
//   clk, rst_n : clock, asynchronous active-low reset
//   srst       : synchronous flush
//   push, din  : write request and data (ignored when full unless popping)
//   pop        : read request (ignored when empty)
//   dout       : current head entry, valid while !empty
//   full/empty : derived from the registered count
//   count      : number of stored entries
// DEPTH must be a power of 2 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       srst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign pop_ok_s  = pop && (count_r != {CW{1'b0}});
  assign push_ok_s = push && ((count_r != DEPTH_C) || pop_ok_s);

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (srst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = (count_r == DEPTH_C);
  assign empty = (count_r == {CW{1'b0}});
  assign count = count_r;

endmodule

// File: rtl/nexys4ddr_uart.sv
// ---------------------------------------------------------------------------
// nexys4ddr_uart
// On-board 8N1 UART (LSB first) for the Nexys 4 DDR.
//   clk, rst_n  : core clock, asynchronous active-low reset
//   uart_rx     : serial line from the host, idle high
//   uart_tx     : serial line to the host, idle high, registered
//   uart_rts_n  : DUT ready to receive (active low)
//   uart_cts_n  : host ready to receive (active low)
//   bus         : byte-stream slave port (nexys4ddr_uart_if.slave)
// Parameters: FREQ (Hz), BAUD, RX_DEPTH (power of 2, >= 4).
// Build option: define NEXYS4DDR_UART_HWFC_EN for RTS/CTS flow control;
// otherwise RTS is held asserted and CTS is ignored.
// ---------------------------------------------------------------------------
module nexys4ddr_uart
  import nexys4ddr_uart_pkg::*;
#(
  parameter int unsigned FREQ     = 100000000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned RX_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx,
  output logic              uart_tx,
  output logic              uart_rts_n,
  input  logic              uart_cts_n,
  nexys4ddr_uart_if.slave   bus
);

  localparam int unsigned DIV = calc_div(FREQ, BAUD);
  localparam int          CNT_W = $clog2(DIV) + 1;
  localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 32'd1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'((DIV / 32'd2) - 32'd1);
  localparam logic [CNT_W-1:0] CNT_Z   = {CNT_W{1'b0}};
  localparam int          FCW = $clog2(RX_DEPTH) + 1;

  // ---------------- RX path ----------------
  logic              rx_meta_r;
  logic              rx_sync_r;
  uart_state_e       rx_state_r;
  logic [CNT_W-1:0]  rx_cnt_r;
  logic [2:0]        rx_bit_r;
  logic [7:0]        rx_shift_r;
  logic              rx_wait_r;
  logic              rx_frame_err_r;
  logic              rx_overflow_r;
  logic              rx_push_s;
  logic              rx_pop_s;
  logic [7:0]        fifo_dout_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [FCW-1:0]    fifo_count_s;

  // Two-flop synchroniser on the incoming serial line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= uart_rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // RX framer: mid-bit sampling, start-glitch rejection, stop-bit check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_r     <= IDLE;
      rx_cnt_r       <= CNT_Z;
      rx_bit_r       <= 3'd0;
      rx_shift_r     <= 8'd0;
      rx_wait_r      <= 1'b0;
      rx_frame_err_r <= 1'b0;
    end else begin
      rx_frame_err_r <= 1'b0;
      case (rx_state_r)
        IDLE: begin
          if (!rx_sync_r) begin
            rx_state_r <= START;
            rx_cnt_r   <= HALF_M1;
          end
        end
        START: begin
          if (rx_cnt_r == CNT_Z) begin
            if (rx_sync_r) begin
              rx_state_r <= IDLE;
            end else begin
              rx_state_r <= DATA;
              rx_cnt_r   <= DIV_M1;
              rx_bit_r   <= 3'd0;
            end
          end else begin
            rx_cnt_r <= rx_cnt_r - CNT_W'(1);
          end
        end
        DATA: begin
          if (rx_cnt_r == CNT_Z) begin
            rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
            rx_cnt_r   <= DIV_M1;
            if (rx_bit_r == 3'd7) begin
              rx_state_r <= STOP;
            end else begin
              rx_bit_r <= rx_bit_r + 3'd1;
            end
          end else begin
            rx_cnt_r <= rx_cnt_r - CNT_W'(1);
          end
        end
        STOP: begin
          // After a bad stop bit, hold here until the line is idle again
          // so a long break is not mistaken for a new start bit.
          if (rx_wait_r) begin
            if (rx_sync_r) begin
              rx_wait_r  <= 1'b0;
              rx_state_r <= IDLE;
            end
          end else if (rx_cnt_r == CNT_Z) begin
            if (rx_sync_r) begin
              rx_state_r <= IDLE;
            end else begin
              rx_frame_err_r <= 1'b1;
              rx_wait_r      <= 1'b1;
            end
          end else begin
            rx_cnt_r <= rx_cnt_r - CNT_W'(1);
          end
        end
        default: begin
          rx_state_r <= IDLE;
        end
      endcase
    end
  end

  assign rx_push_s = (rx_state_r == STOP) && !rx_wait_r &&
                     (rx_cnt_r == CNT_Z) && rx_sync_r;
  assign rx_pop_s  = bus.rx_ready && !fifo_empty_s;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (int'(RX_DEPTH))
  ) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .srst  (1'b0),
    .push  (rx_push_s),
    .din   (rx_shift_r),
    .pop   (rx_pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Sticky overflow: a push found the FIFO full with no pop to make room.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_overflow_r <= 1'b0;
    end else if (rx_push_s && fifo_full_s && !rx_pop_s) begin
      rx_overflow_r <= 1'b1;
    end else begin
      rx_overflow_r <= rx_overflow_r;
    end
  end

  // ---------------- Flow control ----------------
  logic cts_ok_s;

`ifdef NEXYS4DDR_UART_HWFC_EN
  logic cts_meta_r;
  logic cts_sync_r;
  logic rts_n_r;

  // Two-flop synchroniser on the host CTS input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cts_meta_r <= 1'b1;
      cts_sync_r <= 1'b1;
    end else begin
      cts_meta_r <= uart_cts_n;
      cts_sync_r <= cts_meta_r;
    end
  end

  // Deassert RTS while fewer than two slots are free: one in-flight byte of slack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rts_n_r <= 1'b0;
    end else begin
      rts_n_r <= ((FCW'(RX_DEPTH) - fifo_count_s) < FCW'(2));
    end
  end

  assign cts_ok_s   = !cts_sync_r;
  assign uart_rts_n = rts_n_r;
`else
  logic             unused_cts_s;
  logic [FCW-1:0]   unused_count_s;

  assign unused_cts_s   = uart_cts_n;
  assign unused_count_s = fifo_count_s;
  assign cts_ok_s       = 1'b1;
  assign uart_rts_n     = 1'b0;
`endif

  // ---------------- TX path ----------------
  uart_state_e       tx_state_r;
  logic [CNT_W-1:0]  tx_cnt_r;
  logic [2:0]        tx_bit_r;
  logic [7:0]        tx_shift_r;
  logic [7:0]        tx_hold_r;
  logic              tx_ready_r;
  logic              uart_tx_r;
  logic              tx_hs_s;

  assign tx_hs_s = bus.tx_valid && tx_ready_r;

  // TX framer; tx_ready_r doubles as "holding register empty".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_r <= IDLE;
      tx_cnt_r   <= CNT_Z;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'd0;
      tx_hold_r  <= 8'd0;
      tx_ready_r <= 1'b1;
      uart_tx_r  <= 1'b1;
    end else begin
      if (tx_hs_s) begin
        tx_hold_r  <= bus.tx_data;
        tx_ready_r <= 1'b0;
      end
      case (tx_state_r)
        IDLE: begin
          // Start straight from the handshake so the frame takes exactly
          // 10 bit times from the tx_ready fall to its rise.
          if ((tx_hs_s || !tx_ready_r) && cts_ok_s) begin
            tx_state_r <= START;
            tx_cnt_r   <= DIV_M1;
            tx_shift_r <= tx_hs_s ? bus.tx_data : tx_hold_r;
            uart_tx_r  <= 1'b0;
          end
        end
        START: begin
          if (tx_cnt_r == CNT_Z) begin
            tx_state_r <= DATA;
            tx_cnt_r   <= DIV_M1;
            tx_bit_r   <= 3'd0;
            uart_tx_r  <= tx_shift_r[0];
            tx_shift_r <= {1'b0, tx_shift_r[7:1]};
          end else begin
            tx_cnt_r <= tx_cnt_r - CNT_W'(1);
          end
        end
        DATA: begin
          if (tx_cnt_r == CNT_Z) begin
            tx_cnt_r <= DIV_M1;
            if (tx_bit_r == 3'd7) begin
              tx_state_r <= STOP;
              uart_tx_r  <= 1'b1;
            end else begin
              tx_bit_r   <= tx_bit_r + 3'd1;
              uart_tx_r  <= tx_shift_r[0];
              tx_shift_r <= {1'b0, tx_shift_r[7:1]};
            end
          end else begin
            tx_cnt_r <= tx_cnt_r - CNT_W'(1);
          end
        end
        STOP: begin
          if (tx_cnt_r == CNT_Z) begin
            tx_state_r <= IDLE;
            tx_ready_r <= 1'b1;
          end else begin
            tx_cnt_r <= tx_cnt_r - CNT_W'(1);
          end
        end
        default: begin
          tx_state_r <= IDLE;
          uart_tx_r  <= 1'b1;
        end
      endcase
    end
  end

  assign uart_tx          = uart_tx_r;
  assign bus.tx_ready     = tx_ready_r;
  assign bus.rx_data      = fifo_dout_s;
  assign bus.rx_valid     = !fifo_empty_s;
  assign bus.rx_overflow  = rx_overflow_r;
  assign bus.rx_frame_err = rx_frame_err_r;

endmodule

// File: tb/tb_nexys4ddr_uart.sv
// ---------------------------------------------------------------------------
// tb_nexys4ddr_uart
// Directed bench. u_dut runs at the board defaults (868 clocks per bit) for
// the TX bit-timing and reset checks; u_fast uses FREQ=1.6 MHz, BAUD=100 kbaud
// (16 clocks per bit) so the RX, FIFO and overflow sequences stay short.
// ---------------------------------------------------------------------------
module tb_nexys4ddr_uart;

  localparam int DIV_D = 868;
  localparam int DIV_F = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_d = 1'b1;
  logic rx_f = 1'b1;
  logic cts_n = 1'b0;
  logic tx_d, tx_f, rts_d, rts_f;

  int n_chk = 0;
  int n_pass = 0;
  int fe_cnt = 0;

  nexys4ddr_uart_if if_d ();
  nexys4ddr_uart_if if_f ();

  nexys4ddr_uart u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_rx    (rx_d),
    .uart_tx    (tx_d),
    .uart_rts_n (rts_d),
    .uart_cts_n (cts_n),
    .bus        (if_d)
  );

  nexys4ddr_uart #(
    .FREQ     (1600000),
    .BAUD     (100000),
    .RX_DEPTH (16)
  ) u_fast (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_rx    (rx_f),
    .uart_tx    (tx_f),
    .uart_rts_n (rts_f),
    .uart_cts_n (cts_n),
    .bus        (if_f)
  );

  always #5 clk = ~clk;

  // Count cycles with the frame-error pulse high.
  always @(negedge clk) if (if_f.rx_frame_err) fe_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Host drives one frame into u_fast; called right after a negedge.
  task automatic send_f(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_f = fr[k];
      repeat (DIV_F) @(negedge clk);
    end
    rx_f = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Decode one frame from tx_f (fast=1) or tx_d (fast=0), sampling mid-bit.
  task automatic recv(input bit fast, output logic [7:0] b, output logic stop_b, output bit found);
    int div;
    div = fast ? DIV_F : DIV_D;
    found = 1'b0;
    b = 8'd0;
    stop_b = 1'b0;
    for (int i = 0; i < 20 * div; i++) begin
      if ((fast ? tx_f : tx_d) == 1'b0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (found) begin
      repeat (div / 2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (div) @(negedge clk);
        b[k] = fast ? tx_f : tx_d;
      end
      repeat (div) @(negedge clk);
      stop_b = fast ? tx_f : tx_d;
    end
  endtask

  // Handshake one byte into u_fast once it is ready.
  task automatic tx_put_f(input logic [7:0] b);
    for (int i = 0; i < 1000 && !if_f.tx_ready; i++) @(negedge clk);
    check("tx_put_ready", 32'(if_f.tx_ready), 32'd1);
    if_f.tx_valid = 1'b1;
    if_f.tx_data  = b;
    @(negedge clk);
    if_f.tx_valid = 1'b0;
  endtask

  task automatic pop_f;
    if_f.rx_ready = 1'b1;
    @(negedge clk);
    if_f.rx_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] fr_a5;
    logic [7:0] rb;
    logic       rs;
    bit         rf;
    int         lows;
    int         bi, j;

    if_d.tx_valid = 1'b0; if_d.tx_data = 8'd0; if_d.rx_ready = 1'b0;
    if_f.tx_valid = 1'b0; if_f.tx_data = 8'd0; if_f.rx_ready = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_uart_tx",   32'(tx_d), 32'd1);
    check("rst_tx_ready",  32'(if_d.tx_ready), 32'd1);
    check("rst_rx_valid",  32'(if_d.rx_valid), 32'd0);
    check("rst_rx_data",   32'(if_d.rx_data), 32'd0);
    check("rst_overflow",  32'(if_d.rx_overflow), 32'd0);
    check("rst_frame_err", 32'(if_d.rx_frame_err), 32'd0);
    check("rst_rts_n",     32'(rts_d), 32'd0);
    rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    check("idle_uart_tx",  32'(tx_d), 32'd1);
    check("idle_tx_ready", 32'(if_d.tx_ready), 32'd1);
    check("idle_rx_valid", 32'(if_d.rx_valid), 32'd0);
    check("idle_rts_n",    32'(rts_d), 32'd0);

    // 8'hA5 at 868 clocks per bit: line 0,1,0,1,0,0,1,0,1,1.
    fr_a5 = {1'b1, 8'hA5, 1'b0};
    if_d.tx_valid = 1'b1;
    if_d.tx_data  = 8'hA5;
    for (int c = 1; c <= 8681; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if_d.tx_valid = 1'b0;
        check("a5_ready_low", 32'(if_d.tx_ready), 32'd0);
      end
      if (c <= 8680) begin
        bi = (c - 1) / DIV_D;
        j  = (c - 1) % DIV_D;
        if (j == 0 || j == DIV_D - 1)
          check($sformatf("a5_bit%0d_%s", bi, (j == 0) ? "first" : "last"), 32'(tx_d), 32'(fr_a5[bi]));
      end
      if (c == 8680) check("a5_ready_still_low", 32'(if_d.tx_ready), 32'd0);
      if (c == 8681) begin
        check("a5_ready_back", 32'(if_d.tx_ready), 32'd1);
        check("a5_line_idle",  32'(tx_d), 32'd1);
      end
    end

    // Host sends 8'h3C; the bench echoes it back like the loopback.
    send_f(8'h3C, 1'b1);
    check("rx3c_valid", 32'(if_f.rx_valid), 32'd1);
    check("rx3c_data",  32'(if_f.rx_data), 32'h3C);
    check("rx3c_no_fe", 32'(fe_cnt), 32'd0);
    rb = if_f.rx_data;
    pop_f();
    check("rx3c_popped", 32'(if_f.rx_valid), 32'd0);
    tx_put_f(rb);
    recv(1'b1, rb, rs, rf);
    check("echo_found", 32'(rf), 32'd1);
    check("echo_data",  32'(rb), 32'h3C);
    check("echo_stop",  32'(rs), 32'd1);

    // Low pulse shorter than half a bit: rejected by the START resample.
    rx_f = 1'b0;
    repeat (4) @(negedge clk);
    rx_f = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_no_valid", 32'(if_f.rx_valid), 32'd0);
    check("glitch_no_fe",    32'(fe_cnt), 32'd0);

    // Stop bit sampled as 0: one error pulse, nothing queued.
    send_f(8'h81, 1'b0);
    check("fe_pulse_cycles", 32'(fe_cnt), 32'd1);
    check("fe_fifo_empty",   32'(if_f.rx_valid), 32'd0);

    // 17 bytes with rx_ready low: 16 kept, the 17th dropped.
    for (int i = 0; i < 17; i++) begin
      send_f(8'(i), 1'b1);
      if (i == 14) begin
`ifdef NEXYS4DDR_UART_HWFC_EN
        check("rts_after_15", 32'(rts_f), 32'd1);
`else
        check("rts_after_15", 32'(rts_f), 32'd0);
`endif
      end
      if (i == 15) check("ovf_at_16", 32'(if_f.rx_overflow), 32'd0);
      if (i == 16) check("ovf_at_17", 32'(if_f.rx_overflow), 32'd1);
    end
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain%0d_valid", i), 32'(if_f.rx_valid), 32'd1);
      check($sformatf("drain%0d_data", i),  32'(if_f.rx_data), 32'(i));
      pop_f();
    end
    check("drain_empty",    32'(if_f.rx_valid), 32'd0);
    check("ovf_sticky",     32'(if_f.rx_overflow), 32'd1);
    repeat (3) @(negedge clk);
    check("rts_after_drain", 32'(rts_f), 32'd0);

    // CTS deasserted while a byte is waiting.
    cts_n = 1'b1;
    repeat (4) @(negedge clk);
    tx_put_f(8'h55);
`ifdef NEXYS4DDR_UART_HWFC_EN
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_f == 1'b0) lows++;
    end
    check("cts_hold_line", 32'(lows), 32'd0);
    check("cts_hold_ready", 32'(if_f.tx_ready), 32'd0);
    cts_n = 1'b0;
`endif
    recv(1'b1, rb, rs, rf);
    check("cts_found", 32'(rf), 32'd1);
    check("cts_data",  32'(rb), 32'h55);
    cts_n = 1'b0;

    // Reset during data bit 3 of 8'hA5 (frame bit 4, a 0).
    @(negedge clk);
    if_d.tx_valid = 1'b1;
    if_d.tx_data  = 8'hA5;
    @(negedge clk);
    if_d.tx_valid = 1'b0;
    repeat (4 * DIV_D + 400 - 1) @(negedge clk);
    check("pre_rst_bit4", 32'(tx_d), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("rst_tx_immediate", 32'(tx_d), 32'd1);
    check("rst_tx_ready",     32'(if_d.tx_ready), 32'd1);
    check("rst_ovf_cleared",  32'(if_f.rx_overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    if_d.tx_valid = 1'b1;
    if_d.tx_data  = 8'h5A;
    @(negedge clk);
    if_d.tx_valid = 1'b0;
    recv(1'b0, rb, rs, rf);
    check("post_rst_found", 32'(rf), 32'd1);
    check("post_rst_data",  32'(rb), 32'h5A);
    check("post_rst_stop",  32'(rs), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
